// File: rtl/divider_control.sv
// divider_control: Moore FSM sequencing a restoring divide-by-repeated-subtraction datapath
module divider_control (
    input  logic Clock,
    input  logic nReset,
    input  logic Start,
    input  logic Test,
    input  logic nBorrow,
    input  logic Overflow,
    output logic LoadA,
    output logic LoadB,
    output logic LoadM,
    output logic EnableOp1,
    output logic EnableOp2,
    output logic EnableZero,
    output logic EnableSub,
    output logic Increment,
    output logic LoadResult,
    output logic Busy,
    output logic Done,
    output logic Error
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        SUB   = 3'd3,
        STORE = 3'd4,
        DONE  = 3'd5,
        ERROR = 3'd6
    } state_e;

    state_e state_q, state_d;

    // State register; reset drops straight to IDLE so every output clears at once
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state; Test freezes the machine, unused encodings fall back to IDLE
    always_comb begin
        state_d = state_q;
        if (!Test) begin
            case (state_q)
                IDLE:    state_d = Start ? LOAD : IDLE;
                LOAD:    state_d = CHECK;
                CHECK:   state_d = !nBorrow ? STORE : (Overflow ? ERROR : SUB);
                SUB:     state_d = CHECK;
                STORE:   state_d = DONE;
                DONE:    state_d = IDLE;
                ERROR:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output decode from registered state only; Test masks everything low
    always_comb begin
        LoadA      = 1'b0;
        LoadB      = 1'b0;
        LoadM      = 1'b0;
        EnableOp1  = 1'b0;
        EnableOp2  = 1'b0;
        EnableZero = 1'b0;
        EnableSub  = 1'b0;
        Increment  = 1'b0;
        LoadResult = 1'b0;
        Done       = 1'b0;
        Error      = 1'b0;
        Busy       = !Test && (state_q != IDLE);
        if (!Test) begin
            case (state_q)
                LOAD: begin
                    LoadA      = 1'b1;
                    EnableOp1  = 1'b1;
                    LoadM      = 1'b1;
                    EnableOp2  = 1'b1;
                    LoadB      = 1'b1;
                    EnableZero = 1'b1;
                end
                SUB: begin
                    LoadA     = 1'b1;
                    EnableSub = 1'b1;
                    LoadB     = 1'b1;
                    Increment = 1'b1;
                end
                STORE:   LoadResult = 1'b1;
                DONE:    Done = 1'b1;
                ERROR: begin
                    Done  = 1'b1;
                    Error = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_divider_control.sv
// tb_divider_control: scoreboard bench driving divider_control against a behavioural datapath
module tb_divider_control;
    logic clk = 1'b0;
    logic nReset, Start, Test;
    logic nBorrow, Overflow;
    logic LoadA, LoadB, LoadM, EnableOp1, EnableOp2, EnableZero;
    logic EnableSub, Increment, LoadResult, Busy, Done, Error;
    logic [11:0] outs;
    logic [7:0] op1, op2, a_q, b_q, m_q, quot, rem;
    int subs, lrs;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int last_q = 0;
    int last_r = 0;

    typedef struct {
        int q;
        int r;
        bit err;
        int lat;
        int se;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    divider_control dut (
        .Clock(clk), .nReset(nReset), .Start(Start), .Test(Test),
        .nBorrow(nBorrow), .Overflow(Overflow),
        .LoadA(LoadA), .LoadB(LoadB), .LoadM(LoadM),
        .EnableOp1(EnableOp1), .EnableOp2(EnableOp2), .EnableZero(EnableZero),
        .EnableSub(EnableSub), .Increment(Increment), .LoadResult(LoadResult),
        .Busy(Busy), .Done(Done), .Error(Error)
    );

    assign outs = {LoadA, LoadB, LoadM, EnableOp1, EnableOp2, EnableZero,
                   EnableSub, Increment, LoadResult, Busy, Done, Error};

    // Behavioural 8-bit datapath the controller steers
    assign nBorrow  = (a_q >= m_q);
    assign Overflow = (b_q == 8'hFF);

    initial begin
        a_q = 0; b_q = 0; m_q = 0; quot = 0; rem = 0; subs = 0; lrs = 0;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (LoadA) a_q <= EnableOp1 ? op1 : (EnableSub ? a_q - m_q : a_q);
        if (LoadM && EnableOp2) m_q <= op2;
        if (LoadB) b_q <= EnableZero ? 8'd0 : (Increment ? b_q + 8'd1 : b_q);
        if (LoadResult) begin
            quot <= b_q;
            rem  <= a_q;
        end
        if (LoadA && EnableOp1) begin
            subs <= 0;
            lrs  <= 0;
        end else begin
            if (EnableSub) subs <= subs + 1;
            if (LoadResult) lrs <= lrs + 1;
        end
    end

    // Scoreboard: every Done pops one expected division and checks it
    always @(negedge clk) begin
        if (nReset && Done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                checks++;
                if (cyc - e.se + 1 !== e.lat) begin
                    errors++;
                    $display("FAIL done_latency got %0d want %0d", cyc - e.se + 1, e.lat);
                end
                checks++;
                if (Error !== e.err) begin
                    errors++;
                    $display("FAIL error_flag got %0b want %0b", Error, e.err);
                end
                checks++;
                if (int'(quot) !== (e.err ? last_q : e.q)) begin
                    errors++;
                    $display("FAIL quotient got %0d want %0d", quot, e.err ? last_q : e.q);
                end
                checks++;
                if (int'(rem) !== (e.err ? last_r : e.r)) begin
                    errors++;
                    $display("FAIL remainder got %0d want %0d", rem, e.err ? last_r : e.r);
                end
                checks++;
                if (subs !== (e.err ? 255 : e.q)) begin
                    errors++;
                    $display("FAIL sub_count got %0d want %0d", subs, e.err ? 255 : e.q);
                end
                checks++;
                if (lrs !== (e.err ? 0 : 1)) begin
                    errors++;
                    $display("FAIL loadresult_count got %0d want %0d", lrs, e.err ? 0 : 1);
                end
                if (!e.err) begin
                    last_q = e.q;
                    last_r = e.r;
                end
            end
        end
    end

    // Called on a falling edge; Start is sampled by the next rising edge
    task automatic start_div(input int a, input int b, input int extra);
        exp_t x;
        for (int i = 0; i < 1000 && Busy; i++) @(negedge clk);
        op1 = 8'(a);
        op2 = 8'(b);
        Start = 1'b1;
        x.err = (b == 0);
        x.q = x.err ? 0 : a / b;
        x.r = x.err ? 0 : a % b;
        x.lat = (x.err ? 513 : 2 * x.q + 4) + extra;
        x.se = cyc + 1;
        sb.push_back(x);
        @(negedge clk);
        Start = 1'b0;
    endtask

    task automatic test_reset();
        nReset = 1'b0; Start = 1'b0; Test = 1'b0; op1 = 0; op2 = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (outs !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got %h want 000", outs);
        end
        nReset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (outs !== 12'h000) begin
            errors++;
            $display("FAIL idle_outputs got %h want 000", outs);
        end
    endtask

    task automatic test_div(input int a, input int b, input string name);
        start_div(a, b, 0);
        for (int i = 0; i < 600 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout pending %0d want 0", name, sb.size());
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        start_div(9, 3, 0);
        for (int i = 0; i < 20 && !EnableSub; i++) @(negedge clk);
        #2 nReset = 1'b0;
        #1;
        checks++;
        if (outs !== 12'h000) begin
            errors++;
            $display("FAIL async_reset_outputs got %h want 000", outs);
        end
        sb.delete();
        @(negedge clk);
        checks++;
        if (lrs !== 0) begin
            errors++;
            $display("FAIL abort_loadresult got %0d want 0", lrs);
        end
        nReset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle got %0b want 0", Busy);
        end
        test_div(9, 3, "after_abort");
    endtask

    task automatic test_freeze();
        start_div(9, 3, 5);
        for (int i = 0; i < 20 && !EnableSub; i++) @(negedge clk);
        Test = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (outs !== 12'h000) begin
                errors++;
                $display("FAIL freeze_outputs step %0d got %h want 000", k, outs);
            end
            @(negedge clk);
        end
        Test = 1'b0;
        #1;
        checks++;
        if (EnableSub !== 1'b1 || LoadA !== 1'b1) begin
            errors++;
            $display("FAIL freeze_resume_sub got %h want SUB outputs", outs);
        end
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL freeze_timeout pending %0d want 0", sb.size());
        end
        @(negedge clk);
    endtask

    task automatic test_busy_start();
        start_div(9, 3, 0);
        repeat (2) @(negedge clk);
        Start = 1'b1;
        op1 = 8'd7;
        op2 = 8'd9;
        for (int i = 0; i < 50 && !Done; i++) @(negedge clk);
        checks++;
        if (Done !== 1'b1) begin
            errors++;
            $display("FAIL busy_start_done got %0b want 1", Done);
        end
        @(negedge clk);
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL held_start_idle got %0b want 0", Busy);
        end
        sb.push_back('{q: 0, r: 7, err: 1'b0, lat: 4, se: cyc + 1});
        @(negedge clk);
        checks++;
        if (outs !== 12'b111111_000_100) begin
            errors++;
            $display("FAIL held_start_load got %b want 111111000100", outs);
        end
        Start = 1'b0;
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL held_start_timeout pending %0d want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_div(9, 3, "div_9_3");
        test_div(7, 9, "div_7_9");
        test_div(255, 1, "div_255_1");
        test_div(5, 0, "div_by_zero");
        test_reset_abort();
        test_freeze();
        test_busy_start();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
